// File: rtl/toymips_pkg.sv
// Shared toyMIPS definitions: instruction-memory controller state encoding,
// the architectural NOP word and the PC-to-word-index helper.
package toymips_pkg;

  localparam logic [1:0] IMEM_IDLE  = 2'd0;
  localparam logic [1:0] IMEM_LOAD  = 2'd1;
  localparam logic [1:0] IMEM_READY = 2'd2;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  // Full word index of a byte PC; callers slice it for addressing and use
  // the whole value for the range check so high PCs never alias.
  function automatic logic [63:0] imem_pc_word(input logic [63:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Load-stream and fetch-port bundle of the loadable instruction memory.
// The master drives load words and fetch requests; the slave is the memory.
interface imem_loadable_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);

  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_ovf;
  logic              if_req;
  logic [PC_W-1:0]   if_pc;
  logic              if_hold;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_insn;
  logic              if_err;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, if_req, if_pc, if_hold,
    input  ld_ready, ld_done, ld_ovf, if_stall, if_valid, if_insn, if_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, if_req, if_pc, if_hold,
    output ld_ready, ld_done, ld_ovf, if_stall, if_valid, if_insn, if_err
  );

endinterface

// File: rtl/imem_ram_1w1r.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered
// read port; contents and read register are deliberately not reset.
module imem_ram_1w1r #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read register only updates on a read so the last fetched word persists.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the toyMIPS fetch stage: boot-time load stream,
// one-cycle fetch port, and an IDLE/LOAD/READY controller that keeps them apart.
module imem_loadable
  import toymips_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input logic            clk,
  input logic            rst_n,
  imem_loadable_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        r_state, w_state_d;
  logic [AW-1:0]     r_ptr, w_ptr_d;
  logic              r_ovf, w_ovf_d;
  logic              r_valid, w_valid_d;
  logic              r_err, w_err_d;
  logic              r_nop, w_nop_d;
  logic              w_fetch, w_bad, w_we, w_re;
  logic [63:0]       w_pc_word;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_pc_word = imem_pc_word(64'(bus.if_pc));
  assign w_idx     = w_pc_word[AW-1:0];
  assign w_bad     = (bus.if_pc[1:0] != 2'b00) || (w_pc_word >= 64'(DEPTH));
  assign w_fetch   = (r_state == IMEM_READY) && bus.if_req && !bus.if_hold;
  assign w_re      = w_fetch && !w_bad;
  assign w_we      = (r_state == IMEM_LOAD) && bus.ld_valid;

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_ovf_d   = r_ovf;
    case (r_state)
      IMEM_IDLE, IMEM_READY: begin
        if (bus.ld_start) begin
          w_state_d = IMEM_LOAD;
          w_ptr_d   = '0;
          w_ovf_d   = 1'b0;
        end
      end
      IMEM_LOAD: begin
        if (bus.ld_valid) begin
          w_ptr_d = r_ptr + 1'b1;
          if (bus.ld_last) begin
            w_state_d = IMEM_READY;
          end else if (r_ptr == AW'(DEPTH - 1)) begin
            // Array full without a last marker: stop accepting and flag it.
            w_state_d = IMEM_READY;
            w_ovf_d   = 1'b1;
          end
        end
      end
      default: w_state_d = IMEM_IDLE;
    endcase
  end

  // Hold freezes every fetch output; otherwise valid tracks the accepted request.
  always_comb begin
    w_valid_d = r_valid;
    w_err_d   = r_err;
    w_nop_d   = r_nop;
    if (!bus.if_hold) begin
      w_valid_d = w_fetch;
      if (w_fetch) begin
        w_err_d = w_bad;
        w_nop_d = w_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IMEM_IDLE;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_nop   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_ovf   <= w_ovf_d;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
      r_nop   <= w_nop_d;
    end
  end

  imem_ram_1w1r #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_ptr),
    .i_wdata(bus.ld_data),
    .i_re   (w_re),
    .i_raddr(w_idx),
    .o_rdata(w_rdata)
  );

  assign bus.ld_ready = (r_state == IMEM_LOAD);
  assign bus.ld_done  = (r_state == IMEM_READY);
  assign bus.ld_ovf   = r_ovf;
  assign bus.if_stall = (r_state != IMEM_READY);
  assign bus.if_valid = r_valid;
  assign bus.if_err   = r_err;
  assign bus.if_insn  = r_nop ? NOP_WORD : w_rdata;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed and randomized checks of imem_loadable against a behavioural model
// of the load stream, image contents and one-cycle fetch port.
module tb_imem_loadable;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic rst_n;

  imem_loadable_if #(.DATA_W(32), .PC_W(32)) bus ();

  imem_loadable #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .PC_W    (32),
    .NOP_WORD(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {MIdle, MLoad, MReady} mmode_t;

  mmode_t      m_mode;
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];
  logic        m_valid, m_err, m_ovf;
  logic [31:0] m_insn;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] img [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = MIdle;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_insn  = NOP;
  endtask

  task automatic model_edge(input logic st, input logic v, input logic [31:0] d,
                            input logic lst, input logic rq, input logic [31:0] pc,
                            input logic hd);
    logic [31:0] widx;
    widx = pc >> 2;
    if (!hd) begin
      if (m_mode == MReady && rq) begin
        m_valid = 1'b1;
        if (pc[1:0] != 2'b00 || widx >= DEPTH) begin
          m_err  = 1'b1;
          m_insn = NOP;
        end else begin
          m_err  = 1'b0;
          m_insn = m_mem[widx];
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    case (m_mode)
      MIdle, MReady: if (st) begin
        m_mode = MLoad;
        m_cnt  = 0;
        m_ovf  = 1'b0;
      end
      default: if (v) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        if (lst) m_mode = MReady;
        else if (m_cnt == DEPTH) begin
          m_mode = MReady;
          m_ovf  = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("ld_ready", 32'(bus.ld_ready), 32'(m_mode == MLoad));
    chk("ld_done",  32'(bus.ld_done),  32'(m_mode == MReady));
    chk("ld_ovf",   32'(bus.ld_ovf),   32'(m_ovf));
    chk("if_stall", 32'(bus.if_stall), 32'(m_mode != MReady));
    chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
    chk("if_err",   32'(bus.if_err),   32'(m_err));
    chk("if_insn",  bus.if_insn,       m_insn);
  endtask

  task automatic step(input logic st, input logic v, input logic [31:0] d, input logic lst,
                      input logic rq, input logic [31:0] pc, input logic hd);
    bus.ld_start = st;
    bus.ld_valid = v;
    bus.ld_data  = d;
    bus.ld_last  = lst;
    bus.if_req   = rq;
    bus.if_pc    = pc;
    bus.if_hold  = hd;
    @(posedge clk);
    #1;
    model_edge(st, v, d, lst, rq, pc, hd);
    check_all();
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load_word(input logic [31:0] d, input logic lst);
    step(1'b0, 1'b1, d, lst, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hd);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, pc, hd);
  endtask

  initial begin
    logic [31:0] pc;
    logic        st, rq;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.if_req = 1'b0;   bus.if_pc = '0;      bus.if_hold = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    // 1: reset state, fetch while stalled
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_ld_done",  32'(bus.ld_done),  32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_insn",  bus.if_insn,       NOP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'h0, 1'b0);
    fetch(32'h0, 1'b0);
    chk("t1_stall", 32'(bus.if_stall), 32'd1);
    chk("t1_valid", 32'(bus.if_valid), 32'd0);
    chk("t1_insn",  bus.if_insn,       NOP);

    // 2: four-word image, fetch pc=8
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) load_word(32'h2008_0001 + 32'(i), i == 3);
    chk("t2_done", 32'(bus.ld_done), 32'd1);
    chk("t2_ovf",  32'(bus.ld_ovf),  32'd0);
    fetch(32'h8, 1'b0);
    chk("t2_valid", 32'(bus.if_valid), 32'd1);
    chk("t2_insn",  bus.if_insn,       32'h2008_0003);

    // 3: overflowing stream without a last marker
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      img[i] = $urandom;
      load_word(img[i], 1'b0);
    end
    chk("t3_ovf",   32'(bus.ld_ovf),   32'd1);
    chk("t3_done",  32'(bus.ld_done),  32'd1);
    chk("t3_ready", 32'(bus.ld_ready), 32'd0);
    load_word(32'hBAD0_BAD0, 1'b0);
    fetch(32'hC, 1'b0);
    chk("t3_word3", bus.if_insn, img[3]);

    // 4: misaligned and out-of-range PCs
    fetch(32'h6, 1'b0);
    chk("t4_mis_err",  32'(bus.if_err), 32'd1);
    chk("t4_mis_insn", bus.if_insn,     NOP);
    fetch(DEPTH * 4, 1'b0);
    chk("t4_oob_err",  32'(bus.if_err), 32'd1);
    fetch(32'h8000_0004, 1'b0);
    chk("t4_high_err", 32'(bus.if_err), 32'd1);

    // 5: hold freezes outputs, then a new fetch
    fetch(32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch(32'h6, 1'b1);
      chk("t5_hold_valid", 32'(bus.if_valid), 32'd1);
      chk("t5_hold_insn",  bus.if_insn,       img[1]);
    end
    fetch(32'h0, 1'b0);
    chk("t5_new_insn", bus.if_insn, img[0]);
    idle_cycle();
    chk("t5_drop_valid", 32'(bus.if_valid), 32'd0);
    chk("t5_keep_insn",  bus.if_insn,       img[0]);

    // 6: reset in the middle of a load, then a full reload
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    load_word(32'h1111_0000, 1'b0);
    load_word(32'h1111_0001, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_done", 32'(bus.ld_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'h0, 1'b0);
    chk("t6_stall", 32'(bus.if_stall), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      img[i] = 32'h3000_0000 + 32'(i * 7);
      load_word(img[i], i == 3);
    end
    for (int i = 3; i >= 0; i--) begin
      fetch(32'(i * 4), 1'b0);
      chk("t6_reload", bus.if_insn, img[i]);
    end

    // Randomized traffic against the model; ld_start never shares a cycle with if_req.
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:       pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: pc = $urandom;
      endcase
      st = ($urandom_range(0, 11) == 0);
      rq = !st && ($urandom_range(0, 9) < 6);
      step(st, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0), rq, pc,
           ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
